// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle synchronous imem interface, registered instruction and decode fields.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_cycles
`endif
);

   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   // Handshake: there is no valid/ready pair here. The memory answers the
   // address presented in cycle n on imem_rdata in cycle n+1, always.
   // if_valid qualifies pc_out/instr_out; stall freezes every register.

   typedef enum logic [1:0] {
      ACT_RESET,
      ACT_REDIRECT,
      ACT_HOLD,
      ACT_ADVANCE
   } act_t;

   act_t        act;
   logic [31:0] pc_q;
   logic [31:0] pc_resp_q;
   logic        pend_q;

   always_comb begin
      act = ACT_ADVANCE;
      if (rst) begin
         act = ACT_RESET;
      end else if (redirect_valid) begin
         act = ACT_REDIRECT;
      end else if (stall) begin
         act = ACT_HOLD;
      end
   end

   // While stalled, re-present the pending address so the word is still on
   // imem_rdata in the release cycle.
   assign imem_addr = stall ? pc_resp_q : pc_q;

   always_ff @(posedge clk) begin
      case (act)
         ACT_RESET: begin
            pc_q      <= RESET_PC & PC_ALIGN_MASK;
            pc_resp_q <= RESET_PC & PC_ALIGN_MASK;
            pend_q    <= 1'b0;
            if_valid  <= 1'b0;
            pc_out    <= 32'h0000_0000;
            instr_out <= NOP_INSTR;
         end
         ACT_REDIRECT: begin
            pc_q      <= redirect_pc & PC_ALIGN_MASK;
            pend_q    <= 1'b0;
            if_valid  <= 1'b0;
            instr_out <= NOP_INSTR;
         end
         ACT_HOLD: begin
            pc_q      <= pc_q;
            pc_resp_q <= pc_resp_q;
            pend_q    <= pend_q;
            if_valid  <= if_valid;
            pc_out    <= pc_out;
            instr_out <= instr_out;
         end
         default: begin
            instr_out <= pend_q ? imem_rdata : NOP_INSTR;
            pc_out    <= pc_resp_q;
            if_valid  <= pend_q;
            pc_resp_q <= pc_q;
            pend_q    <= 1'b1;
            pc_q      <= pc_q + 32'd4;
         end
      endcase
   end

   assign opcode = instr_out[6:0];
   assign rd     = instr_out[11:7];
   assign funct3 = instr_out[14:12];
   assign rs1    = instr_out[19:15];
   assign rs2    = instr_out[24:20];
   assign funct7 = instr_out[31:25];

`ifdef FETCH_PERF_CNT_EN
   // A fetch is counted when an advance turns a pending response into a valid output.
   always_ff @(posedge clk) begin
      if (act == ACT_RESET) begin
         fetch_count  <= 32'd0;
         stall_cycles <= 32'd0;
      end else begin
         if (act == ACT_ADVANCE && pend_q) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (act == ACT_HOLD) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
